k6502_seq: RTL

K6502_SEQ -- requirements
Module: k6502_seq

---
 rtl/k6502_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/k6502_seq.sv
// Instruction/cycle sequencer for a 6502-style core: holds the opcode register,
// the one-hot cycle vector feeding the microcode ROM, a sticky jam flag and a fetch counter.
module k6502_seq #(
  parameter logic [7:0] RESET_IR = 8'h00,
  parameter int         CYC_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             rdy,
  input  logic             next,
  output logic [7:0]       ir,
  output logic [CYC_W-1:0] cycle,
  output logic             sync,
  output logic             jam,
  output logic [15:0]      icount
);

  localparam logic [CYC_W-1:0] C_N    = '0;
  localparam logic [CYC_W-1:0] C_0    = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] C_LAST = {1'b1, {(CYC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ILLEGAL,
    ACT_FETCH,
    ACT_IDLE,
    ACT_OVERFLOW,
    ACT_STEP
  } act_t;

  act_t             act;
  logic             cyc_legal;
  logic [7:0]       ir_nxt;
  logic [CYC_W-1:0] cycle_nxt;
  logic             jam_nxt;
  logic [15:0]      icount_nxt;

  // A vector is legal when it has at most one bit set.
  assign cyc_legal = ((cycle & (cycle - C_0)) == C_N);

  always_comb begin
    act = ACT_HOLD;
    if (rdy) begin
      if (!cyc_legal)            act = ACT_ILLEGAL;
      else if (next)             act = ACT_FETCH;
      else if (cycle == C_N)     act = ACT_IDLE;
      else if (cycle == C_LAST)  act = ACT_OVERFLOW;
      else                       act = ACT_STEP;
    end
  end

  always_comb begin
    ir_nxt     = ir;
    cycle_nxt  = cycle;
    jam_nxt    = jam;
    icount_nxt = icount;
    unique case (act)
      ACT_ILLEGAL, ACT_OVERFLOW: begin
        ir_nxt    = RESET_IR;
        cycle_nxt = C_N;
        jam_nxt   = 1'b1;
      end
      ACT_FETCH: begin
        ir_nxt     = data_in;
        cycle_nxt  = C_0;
        icount_nxt = icount + 16'd1;
      end
      ACT_STEP:  cycle_nxt = cycle << 1;
      ACT_IDLE,
      ACT_HOLD:  ;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= RESET_IR;
      cycle  <= C_N;
      jam    <= 1'b0;
      icount <= 16'd0;
    end else begin
      ir     <= ir_nxt;
      cycle  <= cycle_nxt;
      jam    <= jam_nxt;
      icount <= icount_nxt;
    end
  end

  assign sync = (cycle == C_0);

endmodule
